// File: rtl/fsm.sv
// Parking-lot car-direction detector: synchronises the two photo-sensors and
// recognises full enter/exit sequences, emitting a one-clock inc/dec pulse.
module fsm #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec
);

    localparam int unsigned MSB = SYNC_STAGES - 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EN1  = 3'd1;
    localparam logic [2:0] ST_EN2  = 3'd2;
    localparam logic [2:0] ST_EN3  = 3'd3;
    localparam logic [2:0] ST_EX1  = 3'd4;
    localparam logic [2:0] ST_EX2  = 3'd5;
    localparam logic [2:0] ST_EX3  = 3'd6;
    localparam logic [2:0] ST_WAIT = 3'd7;

    logic [MSB:0] a_sync;
    logic [MSB:0] b_sync;
    logic [1:0]   ab;
    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         inc_nxt;
    logic         dec_nxt;

    // Sensor synchronisers; the FSM only ever looks at the last stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[MSB-1:0], a};
            b_sync <= {b_sync[MSB-1:0], b};
        end
    end

    assign ab = {a_sync[MSB], b_sync[MSB]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
        end else begin
            state <= state_nxt;
            inc   <= inc_nxt;
            dec   <= dec_nxt;
        end
    end

    // Next state; pulses fire on the edge that returns EN3/EX3 to IDLE.
    always_comb begin
        state_nxt = state;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                case (ab)
                    2'b10:   state_nxt = ST_EN1;
                    2'b01:   state_nxt = ST_EX1;
                    2'b11:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_IDLE;
                endcase
            end
            ST_EN1: begin
                case (ab)
                    2'b11:   state_nxt = ST_EN2;
                    2'b00:   state_nxt = ST_IDLE;
                    2'b01:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EN1;
                endcase
            end
            ST_EN2: begin
                case (ab)
                    2'b01:   state_nxt = ST_EN3;
                    2'b10:   state_nxt = ST_EN1;
                    2'b00:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EN2;
                endcase
            end
            ST_EN3: begin
                case (ab)
                    2'b00: begin
                        state_nxt = ST_IDLE;
                        inc_nxt   = 1'b1;
                    end
                    2'b11:   state_nxt = ST_EN2;
                    2'b10:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EN3;
                endcase
            end
            ST_EX1: begin
                case (ab)
                    2'b11:   state_nxt = ST_EX2;
                    2'b00:   state_nxt = ST_IDLE;
                    2'b10:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EX1;
                endcase
            end
            ST_EX2: begin
                case (ab)
                    2'b10:   state_nxt = ST_EX3;
                    2'b01:   state_nxt = ST_EX1;
                    2'b00:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EX2;
                endcase
            end
            ST_EX3: begin
                case (ab)
                    2'b00: begin
                        state_nxt = ST_IDLE;
                        dec_nxt   = 1'b1;
                    end
                    2'b11:   state_nxt = ST_EX2;
                    2'b01:   state_nxt = ST_WAIT;
                    default: state_nxt = ST_EX3;
                endcase
            end
            ST_WAIT: begin
                if (ab == 2'b00) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm.sv
// Bench for the car-direction detector: table of sensor steps with expected
// pulse counts, hand-written corner sequences, and a random phase vs a path model.
module tb_fsm;

    localparam int unsigned SYNC = 2;

    logic clk;
    logic reset;
    logic a;
    logic b;
    logic inc;
    logic dec;

    int vec_cnt;
    int err_cnt;

    fsm #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .inc   (inc),
        .dec   (dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position along the enter or exit path of sensor codes.
    logic [1:0] enter_path [5];
    logic [1:0] exit_path  [5];
    int         m_pos;
    int         m_dir;
    bit         m_wait;
    logic [1:0] pend [$];

    function automatic int model_step(input logic [1:0] x);
        logic [1:0] p [5];
        if (m_wait) begin
            if (x == 2'b00) m_wait = 1'b0;
            return 0;
        end
        if (m_pos == 0) begin
            if (x == 2'b10) begin
                m_dir = 0;
                m_pos = 1;
            end else if (x == 2'b01) begin
                m_dir = 1;
                m_pos = 1;
            end else if (x == 2'b11) begin
                m_wait = 1'b1;
            end
            return 0;
        end
        p = (m_dir == 0) ? enter_path : exit_path;
        if (x == p[m_pos+1]) begin
            m_pos = m_pos + 1;
            if (m_pos == 4) begin
                m_pos = 0;
                return (m_dir == 0) ? 1 : 2;
            end
        end else if (x == p[m_pos-1]) begin
            m_pos = m_pos - 1;
        end else if (x != p[m_pos]) begin
            m_wait = 1'b1;
            m_pos  = 0;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_pos  = 0;
        m_dir  = 0;
        m_wait = 1'b0;
        pend.delete();
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the input that reaches the FSM now.
    task automatic tick();
        logic [1:0] x;
        int         r;
        @(posedge clk);
        #1;
        pend.push_back({a, b});
        x = 2'b00;
        if (pend.size() > SYNC) x = pend.pop_front();
        r = model_step(x);
        check("model_inc", inc, logic'(r == 1));
        check("model_dec", dec, logic'(r == 2));
    endtask

    typedef struct {
        logic [1:0] ab;
        int         hold;
        int         n_inc;
        int         n_dec;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic [1:0] ab, input int hold, input int ni, input int nd);
        vec_t v;
        v.ab    = ab;
        v.hold  = hold;
        v.n_inc = ni;
        v.n_dec = nd;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic [1:0] ab, input int hold, output int ni, output int nd);
        a  = ab[1];
        b  = ab[0];
        ni = 0;
        nd = 0;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (inc) ni++;
            if (dec) nd++;
        end
    endtask

    task automatic do_reset_pulse(input string name);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check({name, "_inc_low"}, inc, 1'b0);
        check({name, "_dec_low"}, dec, 1'b0);
        #1;
        model_reset();
        reset = 1'b1;
        pend.push_back({a, b});
    endtask

    int ni;
    int nd;
    int first_inc;
    int last_inc;
    int inc_total;
    int dec_total;
    int hold_len;

    initial begin
        enter_path = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        exit_path  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        vec_cnt = 0;
        err_cnt = 0;
        model_reset();
        a     = 1'b0;
        b     = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_inc", inc, 1'b0);
        check("reset_dec", dec, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Table of {ab, hold cycles, expected inc count, expected dec count}.
        add(2'b00, 5, 0, 0);
        add(2'b10, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b01, 5, 0, 0); add(2'b00, 5, 1, 0);
        add(2'b01, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b10, 5, 0, 0); add(2'b00, 5, 0, 1);
        add(2'b10, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b10, 5, 0, 0); add(2'b00, 5, 0, 0);
        add(2'b10, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b01, 5, 0, 0); add(2'b00, 5, 1, 0);
        add(2'b10, 5, 0, 0); add(2'b01, 5, 0, 0); add(2'b00, 5, 0, 0);
        add(2'b11, 20, 0, 0); add(2'b00, 5, 0, 0);
        add(2'b01, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b01, 5, 0, 0);
        add(2'b11, 5, 0, 0); add(2'b10, 5, 0, 0); add(2'b00, 5, 0, 1);
        add(2'b10, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b00, 5, 0, 0); add(2'b10, 5, 0, 0);
        add(2'b00, 5, 0, 0);
        add(2'b10, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b01, 5, 0, 0); add(2'b10, 5, 0, 0);
        add(2'b00, 5, 0, 0);
        add(2'b01, 5, 0, 0); add(2'b11, 5, 0, 0); add(2'b10, 5, 0, 0); add(2'b00, 30, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].ab, vecs[i].hold, ni, nd);
            check_int($sformatf("vec%0d_inc", i), ni, vecs[i].n_inc);
            check_int($sformatf("vec%0d_dec", i), nd, vecs[i].n_dec);
        end

        // Latency: final clear stable before edge N gives inc high after edge N+SYNC.
        apply(2'b10, 4, ni, nd);
        apply(2'b11, 4, ni, nd);
        apply(2'b01, 4, ni, nd);
        a = 1'b0;
        b = 1'b0;
        first_inc = -1;
        inc_total = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (inc) begin
                inc_total++;
                if (first_inc < 0) first_inc = k;
            end
        end
        check_int("latency_edge", first_inc, SYNC + 1);
        check_int("latency_width", inc_total, 1);

        // Reset mid-sequence, then 11 -> 01 -> 00 must not count a car.
        apply(2'b10, 5, ni, nd);
        apply(2'b11, 5, ni, nd);
        do_reset_pulse("mid_rst");
        apply(2'b11, 5, ni, nd);
        check_int("post_rst_11", ni + nd, 0);
        apply(2'b01, 5, ni, nd);
        check_int("post_rst_01", ni + nd, 0);
        apply(2'b00, 5, ni, nd);
        check_int("post_rst_00", ni, 0);

        // Reset arriving while the final clear is still in the synchroniser.
        apply(2'b10, 4, ni, nd);
        apply(2'b11, 4, ni, nd);
        apply(2'b01, 4, ni, nd);
        a = 1'b0;
        b = 1'b0;
        tick();
        do_reset_pulse("abort_rst");
        apply(2'b00, 6, ni, nd);
        check_int("abort_no_inc", ni, 0);

        // Back-to-back cars, one clock per step.
        inc_total = 0;
        dec_total = 0;
        first_inc = -1;
        last_inc  = -1;
        for (int r = 0; r < 2; r++) begin
            for (int s = 1; s <= 4; s++) begin
                apply(enter_path[s], 1, ni, nd);
                if (ni > 0) begin
                    inc_total++;
                    if (first_inc < 0) first_inc = r * 4 + s; else last_inc = r * 4 + s;
                end
                dec_total += nd;
            end
        end
        for (int k = 9; k <= 14; k++) begin
            apply(2'b00, 1, ni, nd);
            if (ni > 0) begin
                inc_total++;
                if (first_inc < 0) first_inc = k; else last_inc = k;
            end
            dec_total += nd;
        end
        check_int("b2b_inc_count", inc_total, 2);
        check_int("b2b_dec_count", dec_total, 0);
        vec_cnt++;
        if (last_inc - first_inc < 4) begin
            err_cnt++;
            $display("FAIL b2b_spacing: got %0d cycles expected >= 4", last_inc - first_inc);
        end

        // Random sensor activity, biased toward single-bit changes.
        for (int n = 0; n < 300; n++) begin
            logic [1:0] nx;
            nx = {a, b};
            if ($urandom_range(0, 3) == 0) nx = 2'($urandom_range(0, 3));
            else nx[$urandom_range(0, 1)] = ~nx[$urandom_range(0, 1) == 0 ? 0 : 1];
            hold_len = $urandom_range(1, 4);
            apply(nx, hold_len, ni, nd);
        end
        apply(2'b00, 8, ni, nd);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
